random_spawn_picker: RTL and testbench
======================================

RANDOM_SPAWN_PICKER -- requirements
Module: random_spawn_picker

Interface
REQ-001 Parameter MAX_TRIES, default 16: maximum wall-map lookups per request before giving up (range 1..255).
REQ-002 Parameter MAP_W, default 40: maze width in 16-px tiles; map height is fixed at 30 tiles.
REQ-003 Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 X_rand  input  10  constrained random pixel X from the upstream dual LFSR; changes every cycle.
REQ-006 Y_rand  input  10  constrained random pixel Y from the upstream dual LFSR; changes every cycle.
REQ-007 spawn_req  input  1  request for one spawn position; sampled only in IDLE.
REQ-008 wall_rd_addr  output  11  wall-map ROM address, tile_y*MAP_W + tile_x.
REQ-009 wall_rd_en  output  1  ROM read strobe.
REQ-010 wall_rd_data  input  1  ROM data (1 = wall), valid the cycle after wall_rd_en.
REQ-011 spawn_x  output  10  accepted pixel X at the tile centre.
REQ-012 spawn_y  output  10  accepted pixel Y at the tile centre.
REQ-013 spawn_valid  output  1  one-cycle pulse when spawn_x and spawn_y are updated.
REQ-014 spawn_fail  output  1  one-cycle pulse when MAX_TRIES lookups are exhausted.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, SAMPLE, ADDR and CHECK.
REQ-017 IDLE with spawn_req=1: at the clock edge, capture X_rand/Y_rand, clear the try counter, go to ADDR.
REQ-018 SAMPLE: at the clock edge, capture X_rand/Y_rand (the LFSR has advanced), go to ADDR.
REQ-019 Tile computation:
- tile_x = captured X[9:4], clamped to MAP_W-1.
- tile_y = captured Y[9:4], clamped to 29.
REQ-020 ADDR: wall_rd_en=1 and wall_rd_addr valid for exactly this cycle; the try counter increments at the edge; go to CHECK.
REQ-021 CHECK, wall_rd_data=0: load the outputs, pulse spawn_valid in the next cycle, go to IDLE.
- spawn_x = tile_x*16+8.
- spawn_y = tile_y*16+8.
REQ-022 CHECK, wall_rd_data=1, try counter < MAX_TRIES: go to SAMPLE.
REQ-023 CHECK, wall_rd_data=1, try counter = MAX_TRIES: pulse spawn_fail in the next cycle, go to IDLE; spawn_x/spawn_y unchanged.
REQ-024 Latency from the spawn_req edge to spawn_valid high SHALL be 3 cycles on a first-try hit, plus 3 cycles per rejection.
REQ-025 spawn_req while busy=1 SHALL be ignored and not queued.
REQ-026 spawn_req held high SHALL start a new request in the cycle where the spawn_valid or spawn_fail pulse is high (state is IDLE).
REQ-027 wall_rd_addr SHALL be 0 whenever wall_rd_en=0.
REQ-028 spawn_valid and spawn_fail SHALL never be high together.

Reset
REQ-029 Reset=1 SHALL force state IDLE, try counter 0, and all of the following to 0: spawn_x, spawn_y, spawn_valid, spawn_fail, busy, wall_rd_en, wall_rd_addr.
REQ-030 Reset mid-request SHALL abort it with no spawn_valid or spawn_fail pulse.
REQ-031 Reset SHALL take priority over spawn_req in the same cycle.

Configuration
REQ-032 Macro SPAWN_EXCLUDE_EN defined:
- Adds inputs pac_x and pac_y (10 bits each).
- In CHECK, a candidate SHALL be treated as a wall when |tile_x - pac_x[9:4]| <= 2 and |tile_y - pac_y[9:4]| <= 2.
REQ-033 Macro SPAWN_EXCLUDE_EN undefined: the pac_x/pac_y ports SHALL be absent and only wall_rd_data decides.

Verification
REQ-034 X_rand=200, Y_rand=100, spawn_req for 1 cycle, ROM all free -> wall_rd_addr=252; spawn_valid 3 cycles later; spawn_x=200, spawn_y=104.
REQ-035 First candidate a wall, second X=320, Y=240 free -> exactly 2 read strobes; spawn_valid 6 cycles after the request; spawn_x=328, spawn_y=248.
REQ-036 ROM all walls, MAX_TRIES=16 -> 16 read strobes, spawn_fail at cycle 48, spawn_valid never asserted, spawn_x/spawn_y unchanged.
REQ-037 X_rand=1023, Y_rand=1023 -> wall_rd_addr=29*40+39=1199; on acceptance spawn_x=632, spawn_y=472.
REQ-038 Reset asserted in CHECK -> busy=0 next cycle, no pulses; spawn_req pulses during busy produce no second result.
REQ-039 With SPAWN_EXCLUDE_EN, pac_x=200, pac_y=100, candidate X=216, Y=116 -> rejected; candidate X=264, Y=100 -> accepted.

Source files
------------

// File: rtl/random_spawn_picker.sv
// random_spawn_picker
//
// Picks a random free tile in the maze wall map and reports its centre pixel.
// One request samples the upstream LFSR pair, converts the pixel position to
// a tile, and reads the wall-map ROM for that tile. A wall means another
// sample is taken. After MAX_TRIES walls the request gives up with a fail
// pulse.
//
// Parameters
//   MAX_TRIES  wall-map lookups per request before giving up (1..255)
//   MAP_W      maze width in 16-px tiles (1..64); the height is fixed at 30
//
// Optional feature (macro SPAWN_EXCLUDE_EN)
//   Adds pac_x_i/pac_y_i. Candidates within 2 tiles of the player on both
//   axes are rejected as if they were walls.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         synchronous active-high reset
//   x_rand_i        random pixel X from the LFSR; changes every cycle
//   y_rand_i        random pixel Y from the LFSR; changes every cycle
//   spawn_req_i     request one spawn position (only sampled when idle)
//   pac_x_i         player pixel X (SPAWN_EXCLUDE_EN only)
//   pac_y_i         player pixel Y (SPAWN_EXCLUDE_EN only)
//   wall_rd_addr_o  wall-map ROM address tile_y*MAP_W + tile_x, 0 when idle
//   wall_rd_en_o    ROM read strobe
//   wall_rd_data_i  ROM data (1 = wall), valid the cycle after the strobe
//   spawn_x_o       accepted tile centre X in pixels
//   spawn_y_o       accepted tile centre Y in pixels
//   spawn_valid_o   one-cycle pulse when spawn_x_o/spawn_y_o are updated
//   spawn_fail_o    one-cycle pulse when all tries hit walls
//   busy_o          high while a request is in progress
module random_spawn_picker #(
  parameter int MAX_TRIES = 16,
  parameter int MAP_W     = 40
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [9:0]  x_rand_i,
  input  logic [9:0]  y_rand_i,
  input  logic        spawn_req_i,
`ifdef SPAWN_EXCLUDE_EN
  input  logic [9:0]  pac_x_i,
  input  logic [9:0]  pac_y_i,
`endif
  output logic [10:0] wall_rd_addr_o,
  output logic        wall_rd_en_o,
  input  logic        wall_rd_data_i,
  output logic [9:0]  spawn_x_o,
  output logic [9:0]  spawn_y_o,
  output logic        spawn_valid_o,
  output logic        spawn_fail_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    ADDR,
    CHECK
  } state_e;

  localparam logic [5:0]  TILE_X_MAX = 6'(MAP_W - 1);
  localparam logic [5:0]  TILE_Y_MAX = 6'd29;
  localparam logic [10:0] MAP_W_L    = 11'(MAP_W);
  localparam logic [7:0]  TRIES_MAX  = 8'(MAX_TRIES);

  state_e      state_q, state_d;
  logic [5:0]  tileX_q, tileX_d;
  logic [4:0]  tileY_q, tileY_d;
  logic [7:0]  tries_q, tries_d;
  logic [9:0]  spawnX_q, spawnX_d;
  logic [9:0]  spawnY_q, spawnY_d;
  logic        spawnValid_q, spawnValid_d;
  logic        spawnFail_q, spawnFail_d;

  logic [5:0]  rawTileX, rawTileY;
  logic [5:0]  capTileX;
  logic [4:0]  capTileY;
  logic [10:0] tileAddr;
  logic        nearPac;
  logic        blocked;
  logic        triesLeft;
  logic        unusedLowBits;

  // Tile coordinates of the current LFSR sample, clamped into the map so
  // that the rightmost/bottom tiles absorb out-of-range pixels.
  assign rawTileX = x_rand_i[9:4];
  assign rawTileY = y_rand_i[9:4];
  assign capTileX = (rawTileX > TILE_X_MAX) ? TILE_X_MAX : rawTileX;
  assign capTileY = (rawTileY > TILE_Y_MAX) ? TILE_Y_MAX[4:0] : rawTileY[4:0];

  assign tileAddr = 11'(tileY_q) * MAP_W_L + 11'(tileX_q);

`ifdef SPAWN_EXCLUDE_EN
  logic [5:0] pacTileX, pacTileY;
  logic [5:0] distX, distY;

  // Chebyshev-style box around the player; both axes must be close.
  assign pacTileX = pac_x_i[9:4];
  assign pacTileY = pac_y_i[9:4];
  assign distX    = (tileX_q >= pacTileX) ? (tileX_q - pacTileX)
                                          : (pacTileX - tileX_q);
  assign distY    = ({1'b0, tileY_q} >= pacTileY) ? ({1'b0, tileY_q} - pacTileY)
                                                  : (pacTileY - {1'b0, tileY_q});
  assign nearPac  = (distX <= 6'd2) && (distY <= 6'd2);
  assign unusedLowBits = ^{x_rand_i[3:0], y_rand_i[3:0], pac_x_i[3:0], pac_y_i[3:0]};
`else
  assign nearPac  = 1'b0;
  assign unusedLowBits = ^{x_rand_i[3:0], y_rand_i[3:0]};
`endif

  assign blocked   = wall_rd_data_i | nearPac;
  assign triesLeft = (tries_q < TRIES_MAX);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A rejected candidate goes back through SAMPLE so the
  // LFSR has advanced before the next capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (spawn_req_i) state_d = ADDR;
      SAMPLE:  state_d = ADDR;
      ADDR:    state_d = CHECK;
      CHECK: begin
        if (blocked && triesLeft) begin
          state_d = SAMPLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs. The address is forced to 0 outside the strobe.
  always_comb begin
    busy_o         = (state_q != IDLE);
    wall_rd_en_o   = (state_q == ADDR);
    wall_rd_addr_o = (state_q == ADDR) ? tileAddr : 11'd0;
  end

  // Datapath next values: candidate capture, try counting and the result
  // registers. The result pulses are registered so they land in the IDLE
  // cycle that follows CHECK.
  always_comb begin
    tileX_d      = tileX_q;
    tileY_d      = tileY_q;
    tries_d      = tries_q;
    spawnX_d     = spawnX_q;
    spawnY_d     = spawnY_q;
    spawnValid_d = 1'b0;
    spawnFail_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn_req_i) begin
          tileX_d = capTileX;
          tileY_d = capTileY;
          tries_d = 8'd0;
        end
      end
      SAMPLE: begin
        tileX_d = capTileX;
        tileY_d = capTileY;
      end
      ADDR: begin
        tries_d = tries_q + 8'd1;
      end
      CHECK: begin
        if (!blocked) begin
          spawnX_d     = {tileX_q, 4'd8};
          spawnY_d     = {1'b0, tileY_q, 4'd8};
          spawnValid_d = 1'b1;
        end else if (!triesLeft) begin
          spawnFail_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tileX_q      <= '0;
      tileY_q      <= '0;
      tries_q      <= '0;
      spawnX_q     <= '0;
      spawnY_q     <= '0;
      spawnValid_q <= 1'b0;
      spawnFail_q  <= 1'b0;
    end else begin
      tileX_q      <= tileX_d;
      tileY_q      <= tileY_d;
      tries_q      <= tries_d;
      spawnX_q     <= spawnX_d;
      spawnY_q     <= spawnY_d;
      spawnValid_q <= spawnValid_d;
      spawnFail_q  <= spawnFail_d;
    end
  end

  assign spawn_x_o     = spawnX_q;
  assign spawn_y_o     = spawnY_q;
  assign spawn_valid_o = spawnValid_q;
  assign spawn_fail_o  = spawnFail_q;

endmodule

// File: tb/tb_random_spawn_picker.sv
// tb_random_spawn_picker
//
// Randomized bench for random_spawn_picker. Each request gets a table of
// candidate pixel positions that is presented on the LFSR inputs exactly in
// the cycles where the picker captures them; random values fill the other
// cycles. A reference model walks the candidate table against the wall map
// and queues the expected ROM strobes and the expected result. An
// independent monitor compares everything the DUT presents with the queues.
module tb_random_spawn_picker;

  localparam int MAX_TRIES = 16;
  localparam int MAP_W     = 40;
  localparam int MAP_H     = 30;

  typedef struct {
    bit isValid;
    int x;
    int y;
    int due;
  } result_t;

  typedef struct {
    int addr;
    int due;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  xRand = '0;
  logic [9:0]  yRand = '0;
  logic        spawnReq = 1'b0;
  logic [10:0] wallRdAddr;
  logic        wallRdEn;
  logic        wallRdData = 1'b0;
  logic [9:0]  spawnX, spawnY;
  logic        spawnValid, spawnFail, busy;
`ifdef SPAWN_EXCLUDE_EN
  logic [9:0]  pacX = '0;
  logic [9:0]  pacY = '0;
  int          pacNextX = 0;
  int          pacNextY = 0;
`endif

  bit      wallMap [0:2047];
  int      xs [MAX_TRIES];
  int      ys [MAX_TRIES];
  int      lastX = 0;
  int      lastY = 0;
  int      cyc = 0;
  int      assertions = 0;
  int      failures = 0;
  result_t resultQ [$];
  strobe_t strobeQ [$];

  always #5 clk = ~clk;

  random_spawn_picker #(
    .MAX_TRIES(MAX_TRIES),
    .MAP_W    (MAP_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .x_rand_i      (xRand),
    .y_rand_i      (yRand),
    .spawn_req_i   (spawnReq),
`ifdef SPAWN_EXCLUDE_EN
    .pac_x_i       (pacX),
    .pac_y_i       (pacY),
`endif
    .wall_rd_addr_o(wallRdAddr),
    .wall_rd_en_o  (wallRdEn),
    .wall_rd_data_i(wallRdData),
    .spawn_x_o     (spawnX),
    .spawn_y_o     (spawnY),
    .spawn_valid_o (spawnValid),
    .spawn_fail_o  (spawnFail),
    .busy_o        (busy)
  );

  // Wall-map ROM with one cycle of read latency.
  always @(posedge clk) begin
    wallRdData <= wallRdEn ? wallMap[wallRdAddr] : 1'b0;
  end

  // Cycle counter used to time-stamp expectations.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic int tileOf(input int pix, input int limit);
    int t;
    t = pix / 16;
    if (t > limit) t = limit;
    return t;
  endfunction

  function automatic bit isBlocked(input int tx, input int ty);
    bit b;
    b = wallMap[ty * MAP_W + tx];
`ifdef SPAWN_EXCLUDE_EN
    if ((tx - pacNextX / 16) <= 2 && (pacNextX / 16 - tx) <= 2 &&
        (ty - pacNextY / 16) <= 2 && (pacNextY / 16 - ty) <= 2) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic fillMap(input int wallPct);
    for (int i = 0; i < 2048; i++) begin
      wallMap[i] = (int'($urandom_range(0, 99)) < wallPct);
    end
  endtask

  task automatic fillCandidates();
    for (int k = 0; k < MAX_TRIES; k++) begin
      xs[k] = int'($urandom_range(0, 1023));
      ys[k] = int'($urandom_range(0, 1023));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      spawnReq = 1'b0;
      xRand = 10'($urandom_range(0, 1023));
      yRand = 10'($urandom_range(0, 1023));
    end
  endtask

  // Issues one request built from xs/ys. Candidate k is captured at the end
  // of relative cycle 3k, its strobe shows in cycle 3k+1 and an accepting
  // check in cycle 3k+2 produces the result in cycle 3k+3. With hold set the
  // request line stays high so the caller can chain the next request into
  // the result cycle; otherwise spurious requests are thrown in while busy.
  task automatic applyStimulus(input bit hold);
    int c0;
    int latency;
    bit accepted;
    int tx, ty;
    @(negedge clk);
`ifdef SPAWN_EXCLUDE_EN
    pacX = 10'(pacNextX);
    pacY = 10'(pacNextY);
`endif
    c0 = cyc;
    accepted = 1'b0;
    latency = 3 * MAX_TRIES;
    for (int k = 0; k < MAX_TRIES; k++) begin
      tx = tileOf(xs[k], MAP_W - 1);
      ty = tileOf(ys[k], MAP_H - 1);
      strobeQ.push_back('{addr: ty * MAP_W + tx, due: c0 + 1 + 3 * k});
      if (!isBlocked(tx, ty)) begin
        accepted = 1'b1;
        latency = 3 * (k + 1);
        lastX = tx * 16 + 8;
        lastY = ty * 16 + 8;
        break;
      end
    end
    resultQ.push_back('{isValid: accepted, x: lastX, y: lastY, due: c0 + latency});
    spawnReq = 1'b1;
    xRand = 10'(xs[0]);
    yRand = 10'(ys[0]);
    for (int j = 1; j < latency; j++) begin
      @(negedge clk);
      if (j % 3 == 0) begin
        xRand = 10'(xs[j / 3]);
        yRand = 10'(ys[j / 3]);
      end else begin
        xRand = 10'($urandom_range(0, 1023));
        yRand = 10'($urandom_range(0, 1023));
      end
      spawnReq = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  endtask

  // Monitor: compares strobes, the idle address, pulse exclusivity and
  // results against the queued expectations.
  initial begin
    result_t r;
    strobe_t s;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (wallRdEn) begin
          if (strobeQ.size() == 0) begin
            checkOutput("unexpected read strobe", 1, 0);
          end else begin
            s = strobeQ.pop_front();
            checkOutput("strobe address", int'(wallRdAddr), s.addr);
            checkOutput("strobe cycle", cyc, s.due);
          end
        end else begin
          checkOutput("address zero without strobe", int'(wallRdAddr), 0);
        end
        checkOutput("valid and fail exclusive", int'(spawnValid & spawnFail), 0);
        if (spawnValid || spawnFail) begin
          if (resultQ.size() == 0) begin
            checkOutput("unexpected result pulse", 1, 0);
          end else begin
            r = resultQ.pop_front();
            checkOutput("result kind valid", int'(spawnValid), int'(r.isValid));
            checkOutput("result spawn_x", int'(spawnX), r.x);
            checkOutput("result spawn_y", int'(spawnY), r.y);
            checkOutput("result cycle", cyc, r.due);
          end
        end
      end
    end
  end

  // Directed scenarios first, then randomized requests.
  initial begin
    int c0;
    bit hold;
    $display("[TB] start");
    fillMap(0);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset spawn_valid", int'(spawnValid), 0);
    checkOutput("reset spawn_fail", int'(spawnFail), 0);
    checkOutput("reset spawn_x", int'(spawnX), 0);
    checkOutput("reset spawn_y", int'(spawnY), 0);
    checkOutput("reset wall_rd_en", int'(wallRdEn), 0);
    checkOutput("reset wall_rd_addr", int'(wallRdAddr), 0);
    reset = 1'b0;
    idle(2);

    // All free, first candidate accepted at tile (12,6).
    fillMap(0);
    fillCandidates();
    xs[0] = 200; ys[0] = 100;
    applyStimulus(1'b0);
    idle(1);
    checkOutput("free map spawn_x", int'(spawnX), 200);
    checkOutput("free map spawn_y", int'(spawnY), 104);
    idle(2);

    // First candidate on a wall, second candidate free.
    fillMap(0);
    fillCandidates();
    xs[0] = 40;  ys[0] = 40;
    xs[1] = 320; ys[1] = 240;
    wallMap[2 * MAP_W + 2] = 1'b1;
    applyStimulus(1'b0);
    idle(1);
    checkOutput("retry spawn_x", int'(spawnX), 328);
    checkOutput("retry spawn_y", int'(spawnY), 248);
    idle(2);

    // All walls: give up after MAX_TRIES, position unchanged.
    fillMap(100);
    fillCandidates();
    applyStimulus(1'b0);
    idle(1);
    checkOutput("all walls spawn_x kept", int'(spawnX), 328);
    checkOutput("all walls spawn_y kept", int'(spawnY), 248);
    idle(2);

    // Clamping at the far corner.
    fillMap(0);
    fillCandidates();
    xs[0] = 1023; ys[0] = 1023;
    applyStimulus(1'b0);
    idle(1);
    checkOutput("corner spawn_x", int'(spawnX), 632);
    checkOutput("corner spawn_y", int'(spawnY), 472);
    idle(2);

    // Held request chains into the result cycle.
    fillMap(30);
    fillCandidates();
    applyStimulus(1'b1);
    fillCandidates();
    applyStimulus(1'b0);
    idle(3);

`ifdef SPAWN_EXCLUDE_EN
    // Candidate next to the player is rejected, one further away accepted.
    fillMap(0);
    fillCandidates();
    pacNextX = 200; pacNextY = 100;
    xs[0] = 216; ys[0] = 116;
    xs[1] = 264; ys[1] = 100;
    applyStimulus(1'b0);
    idle(1);
    checkOutput("exclude spawn_x", int'(spawnX), 264);
    checkOutput("exclude spawn_y", int'(spawnY), 104);
    idle(2);
`endif

    // Reset in CHECK aborts silently; reset beats a simultaneous request.
    fillMap(100);
    fillCandidates();
    @(negedge clk);
    c0 = cyc;
    strobeQ.push_back('{addr: tileOf(ys[0], MAP_H - 1) * MAP_W + tileOf(xs[0], MAP_W - 1),
                        due: c0 + 1});
    spawnReq = 1'b1;
    xRand = 10'(xs[0]);
    yRand = 10'(ys[0]);
    @(negedge clk);
    spawnReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort spawn_valid", int'(spawnValid), 0);
    checkOutput("abort spawn_fail", int'(spawnFail), 0);
    checkOutput("abort spawn_x", int'(spawnX), 0);
    checkOutput("abort spawn_y", int'(spawnY), 0);
    spawnReq = 1'b1;
    @(negedge clk);
    checkOutput("reset over request busy", int'(busy), 0);
    reset = 1'b0;
    spawnReq = 1'b0;
    lastX = 0;
    lastY = 0;
    idle(5);

    // Randomized requests over maps of varying density.
    for (int n = 0; n < 40; n++) begin
      fillMap(int'($urandom_range(20, 80)));
      fillCandidates();
`ifdef SPAWN_EXCLUDE_EN
      pacNextX = int'($urandom_range(0, 639));
      pacNextY = int'($urandom_range(0, 479));
`endif
      hold = ($urandom_range(0, 2) == 0);
      applyStimulus(hold);
      if (!hold) idle(int'($urandom_range(1, 3)));
    end

    idle(10);
    checkOutput("results drained", resultQ.size(), 0);
    checkOutput("strobes drained", strobeQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
